// File: rtl/band_meter_pkg.sv
// rtl/band_meter_pkg.sv - shared widths and bus slicing helpers for the band level meter
package band_meter_pkg;

    localparam int NUM_BANDS  = 4;
    localparam int SAMPLE_W   = 16;
    localparam int MAG_W      = 15;
    localparam int BUS_W      = NUM_BANDS * SAMPLE_W;
    localparam int PEAK_BUS_W = NUM_BANDS * MAG_W;

    function automatic logic [SAMPLE_W-1:0] band_sample(input logic [BUS_W-1:0] bus, input int b);
        return bus[b*SAMPLE_W +: SAMPLE_W];
    endfunction

endpackage

// File: rtl/band_accum.sv
// rtl/band_accum.sv - one band: magnitude extract, window accumulator, mean result
// Optional peak register built when LEVEL_PEAK_EN is defined.
module band_accum
    import band_meter_pkg::*;
#(
    parameter int WIN_LOG2 = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_sample_en,
    input  logic                i_close,
    input  logic [SAMPLE_W-1:0] i_sample,
    output logic [MAG_W-1:0]    o_level
`ifdef LEVEL_PEAK_EN
    ,
    output logic [MAG_W-1:0]    o_peak
`endif
);

    localparam int ACC_W = MAG_W + WIN_LOG2;

    logic [MAG_W-1:0] w_mag;
    logic             w_unused_sign;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] r_acc;

    // Sign is dropped, so negative zero reads as magnitude 0.
    assign w_mag         = i_sample[MAG_W-1:0];
    assign w_unused_sign = i_sample[SAMPLE_W-1];
    assign w_sum         = r_acc + ACC_W'(w_mag);
    assign o_level       = w_sum[ACC_W-1:WIN_LOG2];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_sample_en) begin
            r_acc <= i_close ? '0 : w_sum;
        end
    end

`ifdef LEVEL_PEAK_EN
    logic [MAG_W-1:0] r_peak;
    logic [MAG_W-1:0] w_peak_next;

    assign w_peak_next = (w_mag > r_peak) ? w_mag : r_peak;
    assign o_peak      = w_peak_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_peak <= '0;
        end else if (i_sample_en) begin
            r_peak <= i_close ? '0 : w_peak_next;
        end
    end
`endif

endmodule

// File: rtl/band_level_meter.sv
// rtl/band_level_meter.sv - per-band mean level meter with valid/ready output and sticky overrun
// Define LEVEL_PEAK_EN to build the per-band peak detector; otherwise peak_out is tied to 0.
module band_level_meter
    import band_meter_pkg::*;
#(
    parameter int WIN_LOG2 = 4
) (
    input  logic                  clk_slow,
    input  logic                  rst,
    input  logic                  sample_en,
    input  logic [BUS_W-1:0]      band_in,
    output logic [BUS_W-1:0]      level_out,
    output logic [PEAK_BUS_W-1:0] peak_out,
    output logic                  level_valid,
    input  logic                  level_ready,
    output logic                  overrun
);

    logic [WIN_LOG2-1:0] r_cnt;
    logic [BUS_W-1:0]    r_level;
    logic                r_valid;
    logic                r_overrun;
    logic                w_close;
    logic [MAG_W-1:0]    w_level [NUM_BANDS];
`ifdef LEVEL_PEAK_EN
    logic [MAG_W-1:0]      w_peak [NUM_BANDS];
    logic [PEAK_BUS_W-1:0] r_peak;
`endif

    assign w_close = sample_en && (r_cnt == {WIN_LOG2{1'b1}});

    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
        band_accum #(
            .WIN_LOG2    (WIN_LOG2)
        ) u_accum (
            .i_clk       (clk_slow),
            .i_rst       (rst),
            .i_sample_en (sample_en),
            .i_close     (w_close),
            .i_sample    (band_sample(band_in, b)),
            .o_level     (w_level[b])
`ifdef LEVEL_PEAK_EN
            ,
            .o_peak      (w_peak[b])
`endif
        );
    end

    // A load always wins over a transfer; overrun only when the old result was never taken.
    always_ff @(posedge clk_slow) begin
        if (rst) begin
            r_cnt     <= '0;
            r_level   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (sample_en) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_close) begin
                for (int b = 0; b < NUM_BANDS; b++) begin
                    r_level[b*SAMPLE_W +: SAMPLE_W] <= {1'b0, w_level[b]};
                end
                r_valid <= 1'b1;
                if (r_valid && !level_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (level_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef LEVEL_PEAK_EN
    always_ff @(posedge clk_slow) begin
        if (rst) begin
            r_peak <= '0;
        end else if (w_close) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                r_peak[b*MAG_W +: MAG_W] <= w_peak[b];
            end
        end
    end
    assign peak_out = r_peak;
`else
    assign peak_out = '0;
`endif

    assign level_out   = r_level;
    assign level_valid = r_valid;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_band_level_meter.sv
// tb/tb_band_level_meter.sv - self-checking bench for band_level_meter
module tb_band_level_meter;

    localparam int WIN_LOG2 = 4;
    localparam int WIN      = 1 << WIN_LOG2;

    logic        clk_slow = 1'b0;
    logic        rst = 1'b1;
    logic        sample_en = 1'b0;
    logic        level_ready = 1'b0;
    logic [63:0] band_in = '0;
    logic [63:0] level_out;
    logic [59:0] peak_out;
    logic        level_valid;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] m_level = '0;
    logic [59:0] m_peak  = '0;
    logic        m_valid = 1'b0;
    logic        m_ovr   = 1'b0;
    logic [14:0] win_q [4][$];

    band_level_meter #(.WIN_LOG2(WIN_LOG2)) dut (
        .clk_slow    (clk_slow),
        .rst         (rst),
        .sample_en   (sample_en),
        .band_in     (band_in),
        .level_out   (level_out),
        .peak_out    (peak_out),
        .level_valid (level_valid),
        .level_ready (level_ready),
        .overrun     (overrun)
    );

    always #5 clk_slow = ~clk_slow;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: collect each window's magnitudes, then take mean/max when it holds WIN samples.
    task automatic model_step();
        logic        load;
        logic [63:0] new_level;
        logic [59:0] new_peak;
        load      = 1'b0;
        new_level = '0;
        new_peak  = '0;
        if (rst) begin
            m_level = '0;
            m_peak  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            for (int b = 0; b < 4; b++) win_q[b].delete();
        end else begin
            if (sample_en) begin
                for (int b = 0; b < 4; b++) win_q[b].push_back(band_in[16*b +: 15]);
                if (win_q[0].size() == WIN) begin
                    load = 1'b1;
                    for (int b = 0; b < 4; b++) begin
                        int sum;
                        int mx;
                        sum = 0;
                        mx  = 0;
                        foreach (win_q[b][k]) begin
                            sum += int'(win_q[b][k]);
                            if (int'(win_q[b][k]) > mx) mx = int'(win_q[b][k]);
                        end
                        new_level[16*b +: 16] = 16'(sum / WIN);
`ifdef LEVEL_PEAK_EN
                        new_peak[15*b +: 15] = 15'(mx);
`endif
                        win_q[b].delete();
                    end
                end
            end
            if (load) begin
                if (m_valid && !level_ready) m_ovr = 1'b1;
                m_level = new_level;
                m_peak  = new_peak;
                m_valid = 1'b1;
            end else if (m_valid && level_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_slow);
            model_step();
            #1;
            chk("model_level", level_out, m_level);
            chk("model_peak", {4'h0, peak_out}, {4'h0, m_peak});
            chk("model_valid", {63'h0, level_valid}, {63'h0, m_valid});
            chk("model_overrun", {63'h0, overrun}, {63'h0, m_ovr});
        end
    end

    task automatic cyc(input logic en, input logic [63:0] bus, input logic rdy, input logic r);
        sample_en   = en;
        band_in     = bus;
        level_ready = rdy;
        rst         = r;
        @(negedge clk_slow);
    endtask

    task automatic window(input logic [63:0] bus, input logic rdy, input bit gaps);
        for (int i = 0; i < WIN; i++) begin
            cyc(1'b1, bus, rdy, 1'b0);
            if (gaps) cyc(1'b0, 64'h0, rdy, 1'b0);
        end
    endtask

    initial begin
        @(negedge clk_slow);
        cyc(1'b0, 64'h0, 1'b0, 1'b1);
        cyc(1'b0, 64'h0, 1'b0, 1'b1);
        chk("reset_level", level_out, 64'h0);
        chk("reset_valid", {63'h0, level_valid}, 64'h0);
        chk("reset_overrun", {63'h0, overrun}, 64'h0);

        window({16'h8100, 32'h0, 16'h0100}, 1'b1, 1'b0);
        chk("const_valid", {63'h0, level_valid}, 64'h1);
        chk("const_b0", {48'h0, level_out[15:0]}, 64'h0100);
        chk("const_b3", {48'h0, level_out[63:48]}, 64'h0100);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        chk("const_drop", {63'h0, level_valid}, 64'h0);

        window({4{16'h7FFF}}, 1'b1, 1'b0);
        chk("full_scale", level_out, {4{16'h7FFF}});
        window({4{16'h8000}}, 1'b1, 1'b0);
        chk("neg_zero", level_out, 64'h0);

        for (int i = 0; i < WIN - 1; i++) begin
            cyc(1'b1, 64'h0, 1'b1, 1'b0);
            cyc(1'b0, 64'h0, 1'b1, 1'b0);
        end
        cyc(1'b1, {4{16'h001F}}, 1'b1, 1'b0);
        chk("trunc_gap", {48'h0, level_out[15:0]}, 64'h0001);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);

        window({4{16'h0010}}, 1'b0, 1'b0);
        chk("bp_first_valid", {63'h0, level_valid}, 64'h1);
        chk("bp_first_ovr", {63'h0, overrun}, 64'h0);
        window({4{16'h0020}}, 1'b0, 1'b0);
        chk("bp_second_level", {48'h0, level_out[15:0]}, 64'h0020);
        chk("bp_overrun", {63'h0, overrun}, 64'h1);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        chk("bp_drain_valid", {63'h0, level_valid}, 64'h0);
        chk("bp_sticky_ovr", {63'h0, overrun}, 64'h1);

        for (int i = 0; i < 5; i++) cyc(1'b1, {4{16'h0400}}, 1'b1, 1'b0);
        cyc(1'b1, {4{16'h0400}}, 1'b1, 1'b1);
        chk("rst_mid_level", level_out, 64'h0);
        chk("rst_mid_valid", {63'h0, level_valid}, 64'h0);
        chk("rst_mid_ovr", {63'h0, overrun}, 64'h0);
        chk("rst_mid_peak", {4'h0, peak_out}, 64'h0);
        window({4{16'h0010}}, 1'b1, 1'b0);
        chk("rst_mid_after", level_out, {4{16'h0010}});

        for (int i = 0; i < WIN; i++)
            cyc(1'b1, (i == 7) ? {4{16'h8123}} : {4{16'h0001}}, 1'b1, 1'b0);
        chk("peak_level", {48'h0, level_out[15:0]}, 64'h0013);
`ifdef LEVEL_PEAK_EN
        chk("peak_value", {49'h0, peak_out[14:0]}, 64'h0123);
`else
        chk("peak_tied", {4'h0, peak_out}, 64'h0);
`endif

        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 1) == 1, {$urandom, $urandom},
                $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/band_level_meter.md
# band_level_meter

Per-band level meter that sits directly downstream of the four 16-bit fixed-point FIR band filters. It takes each band's sign-magnitude output, accumulates magnitude over a fixed power-of-two window of sample strobes, and presents the per-band mean level through a valid/ready output register. An optional per-band peak detector can be compiled in.

## Interface
Parameters:
- WIN_LOG2, 4: window length is 2^WIN_LOG2 sample strobes; legal range 1..8.

Ports:
- clk_slow  in  1  sample-rate clock shared with the FIR bands
- rst  in  1  reset; one clock, synchronous, active-high
- sample_en  in  1  one-cycle strobe; band_in is valid in this cycle
- band_in  in  64  band b at bits [16b+15:16b]; sign-magnitude (bit 15 = sign, bits 14:0 = magnitude)
- level_out  out  64  band b mean at bits [16b+15:16b]; bit 15 is always 0
- peak_out  out  60  band b peak magnitude at bits [15b+14:15b]
- level_valid  out  1  level_out and peak_out hold an unconsumed result
- level_ready  in  1  consumer accepts the result when level_valid && level_ready
- overrun  out  1  sticky: an unconsumed result was overwritten

## Operation
- Magnitude: mag_b = band_in[16b+14:16b]. The sign bit is ignored, so 16'h8000 (negative zero) gives magnitude 0.
- Accumulators: one per band, width 15+WIN_LOG2, so overflow is impossible. Window counter is WIN_LOG2 bits wide.
- On sample_en, if the counter is not 2^WIN_LOG2-1: acc_b += mag_b and the counter increments.
- On sample_en, if the counter is 2^WIN_LOG2-1 (the window-closing strobe):
  - result_b = (acc_b + mag_b) >> WIN_LOG2, which is truncation toward zero.
  - result_b is loaded into the output register, and level_valid is set.
  - acc_b is set to 0 and the counter wraps to 0. The closing sample belongs only to the window it closes.
- Cycles without sample_en leave the accumulators and counter unchanged.
- Output handshake:
  - Transfer occurs on a cycle with level_valid && level_ready. level_valid then clears unless a load happens in the same cycle.
  - Load and transfer in the same cycle: the new result loads, level_valid stays 1, and overrun is unchanged.
  - Load while level_valid && !level_ready: the new result overwrites the old one and overrun is set to 1.
  - level_out is stable while level_valid && !level_ready and no load occurs.
- overrun is cleared only by rst.
- Reset clears everything: accumulators 0, counter 0, level_out 0, peak_out 0, level_valid 0, overrun 0. A partially filled window is discarded.
- rst has priority over sample_en in the same cycle.

## Timing
- Results are registered. level_valid rises on the clock edge that samples the window-closing sample_en, so it is visible the cycle after that strobe.
- Latency from the closing strobe to level_out: 1 cycle.
- Window length is exactly 2^WIN_LOG2 strobes, independent of gaps between strobes.
- sample_en is allowed on back-to-back cycles.
- level_ready may be high with level_valid low; it then has no effect.

## Configuration
- LEVEL_PEAK_EN defined:
  - A per-band peak register tracks max(mag_b) over the window, including the closing sample.
  - It loads into peak_out alongside level_out and resets to 0 at window close and on rst.
- LEVEL_PEAK_EN undefined:
  - No peak registers are built and peak_out is tied to 0.
  - The ports are unchanged, so instantiations and benches need no edits.

## Structure
- Shared package band_meter_pkg holds:
  - NUM_BANDS = 4
  - SAMPLE_W = 16
  - MAG_W = 15
  - slicing helpers for band b within the flat buses
- Sub-module band_accum, one instance per band:
  - contains the magnitude extract, accumulator, optional peak register and result computation
  - the top level keeps the shared window counter, output register, handshake and overrun

## Test plan
- Constant level, WIN_LOG2=4: band0 = 16'h0100 and band3 = 16'h8100 for 16 strobes, level_ready=1 -> level_valid pulses one cycle after strobe 16; band0 and band3 levels = 16'h0100.
- Full scale: all bands 16'h7FFF for 16 strobes -> each level = 16'h7FFF, no wrap. Bands held at 16'h8000 -> each level = 0.
- Truncation and gaps: 15 strobes of 16'h0000 then one of 16'h001F, with idle cycles between strobes -> level = 16'h0001.
- Backpressure:
  - level_ready=0 across two windows, first window 16'h0010 and second 16'h0020 -> level_out = 16'h0020, overrun=1.
  - Then level_ready=1 -> level_valid drops the next cycle; overrun stays 1 until rst.
- Reset mid-window: 5 strobes of 16'h0400, then rst for 1 cycle, then 16 strobes of 16'h0010 -> level = 16'h0010, and all outputs read 0 in the cycle after rst.
- Peak (LEVEL_PEAK_EN): one strobe of 16'h8123 among 15 strobes of 16'h0001 -> peak_out band = 15'h0123, level = 16'h0013. Built without the macro -> peak_out = 0.
